// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Registered, flow-controlled RV32I decode stage. Instructions arrive on a
// valid/ready interface, are decoded combinationally and captured into a
// 2-entry elastic buffer (output register OUT plus skid register SKID).
// The decoded fields leave on a second valid/ready interface one cycle after
// acceptance. in_ready_o depends only on registered state, so there is no
// combinational path from out_ready_i back to the fetch side.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   in_valid_i   fetch presents an instruction
//   in_ready_o   stage can accept an instruction (SKID empty)
//   insn_i       raw instruction
//   pc_i         instruction PC
//   flush_i      synchronous flush, drops buffered and incoming instructions
//   out_valid_o  decoded outputs valid
//   out_ready_i  execute consumes the outputs
//   pc_o         PC of the decoded instruction
//   insn_o       raw instruction passthrough
//   opcode_o     insn[6:0]
//   rd_o         destination register (R/I/U/J), else 0
//   rs1_o        source register 1 (R/I/S/B), else 0
//   rs2_o        source register 2 (R/S/B), else 0
//   funct3_o     funct3 (R/I/S/B), else 0
//   funct7_o     funct7 (R and OP-IMM shifts), else 0
//   shamt_o      shift amount for OP/OP-IMM shifts, else 0
//   imm_o        sign-extended immediate, 0 for R format
//   illegal_o    instruction is not valid RV32I
//   count_o      number of instructions handed to execute (wraps)
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [DWIDTH-1:0]    insn_i,
  input  logic [AWIDTH-1:0]    pc_i,
  input  logic                 flush_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [AWIDTH-1:0]    pc_o,
  output logic [DWIDTH-1:0]    insn_o,
  output logic [6:0]           opcode_o,
  output logic [4:0]           rd_o,
  output logic [4:0]           rs1_o,
  output logic [4:0]           rs2_o,
  output logic [2:0]           funct3_o,
  output logic [6:0]           funct7_o,
  output logic [4:0]           shamt_o,
  output logic [DWIDTH-1:0]    imm_o,
  output logic                 illegal_o,
  output logic [CNT_WIDTH-1:0] count_o
);

  // ---------------------------------------------------------------------------
  // Opcode table. The index order matters: the format classes below are
  // built from contiguous slices of the hit vector.
  // ---------------------------------------------------------------------------
  localparam logic [6:0] OPC_OP       = 7'b0110011; // 0  R
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011; // 1  I
  localparam logic [6:0] OPC_LOAD     = 7'b0000011; // 2  I
  localparam logic [6:0] OPC_JALR     = 7'b1100111; // 3  I
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011; // 4  I
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111; // 5  I
  localparam logic [6:0] OPC_STORE    = 7'b0100011; // 6  S
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011; // 7  B
  localparam logic [6:0] OPC_LUI      = 7'b0110111; // 8  U
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111; // 9  U
  localparam logic [6:0] OPC_JAL      = 7'b1101111; // 10 J

  localparam int NUM_OPC = 11;
  localparam logic [6:0] OPC_TABLE [NUM_OPC] = '{
    OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM,
    OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL
  };

  typedef struct packed {
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] insn;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        shamt;
    logic [DWIDTH-1:0] imm;
    logic              illegal;
  } dec_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // OUT empty
    ST_ONE   = 2'd1,  // OUT full, SKID empty
    ST_TWO   = 2'd2   // OUT and SKID full
  } state_t;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic [6:0]         opcode;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic [NUM_OPC-1:0] opc_hit;
  logic               is_r, is_i, is_s, is_b, is_u, is_j;
  logic               is_opimm, is_load, is_jalr;
  logic               f3_is_shift;
  logic               opimm_shift, op_shift;
  dec_t               dec_d;

  assign opcode = insn_i[6:0];
  assign f3     = insn_i[14:12];
  assign f7     = insn_i[31:25];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPC; gi++) begin : g_opc_match
      assign opc_hit[gi] = (opcode == OPC_TABLE[gi]);
    end
  endgenerate

  assign is_r     = opc_hit[0];
  assign is_i     = |opc_hit[5:1];
  assign is_s     = opc_hit[6];
  assign is_b     = opc_hit[7];
  assign is_u     = |opc_hit[9:8];
  assign is_j     = opc_hit[10];
  assign is_opimm = opc_hit[1];
  assign is_load  = opc_hit[2];
  assign is_jalr  = opc_hit[3];

  assign f3_is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign opimm_shift = is_opimm & f3_is_shift;
  assign op_shift    = is_r & f3_is_shift;

  always_comb begin
    dec_d         = '0;
    dec_d.pc      = pc_i;
    dec_d.insn    = insn_i;
    dec_d.opcode  = opcode;

    if (is_r | is_i | is_u | is_j) dec_d.rd     = insn_i[11:7];
    if (is_r | is_i | is_s | is_b) dec_d.rs1    = insn_i[19:15];
    if (is_r | is_s | is_b)        dec_d.rs2    = insn_i[24:20];
    if (is_r | is_i | is_s | is_b) dec_d.funct3 = f3;
    if (is_r | opimm_shift)        dec_d.funct7 = f7;
    if (op_shift | opimm_shift)    dec_d.shamt  = insn_i[24:20];

    // Immediate generation; R format and unknown opcodes leave imm at zero.
    if (is_i) begin
      if (opimm_shift) dec_d.imm = {27'b0, insn_i[24:20]};
      else             dec_d.imm = {{20{insn_i[31]}}, insn_i[31:20]};
    end else if (is_s) begin
      dec_d.imm = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
    end else if (is_b) begin
      dec_d.imm = {{19{insn_i[31]}}, insn_i[31], insn_i[7],
                   insn_i[30:25], insn_i[11:8], 1'b0};
    end else if (is_u) begin
      dec_d.imm = {insn_i[31:12], 12'b0};
    end else if (is_j) begin
      dec_d.imm = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12],
                   insn_i[20], insn_i[30:21], 1'b0};
    end

    // Illegal-instruction detection. Fields are still forwarded as decoded.
    dec_d.illegal = ~(|opc_hit) | (insn_i[1:0] != 2'b11);
    if (is_r) begin
      if ((f7 != 7'b0000000) && (f7 != 7'b0100000)) dec_d.illegal = 1'b1;
      // Only SUB (000) and SRA (101) use the alternate funct7.
      if ((f7 == 7'b0100000) && (f3 != 3'b000) && (f3 != 3'b101))
        dec_d.illegal = 1'b1;
    end
    if (opimm_shift) begin
      if ((f7 != 7'b0000000) && (f7 != 7'b0100000)) dec_d.illegal = 1'b1;
      // Only SRAI (101) uses the alternate funct7.
      if ((f7 == 7'b0100000) && (f3 != 3'b101)) dec_d.illegal = 1'b1;
    end
    if (is_load && ((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)))
      dec_d.illegal = 1'b1;
    if (is_s && (f3 > 3'b010))
      dec_d.illegal = 1'b1;
    if (is_b && ((f3 == 3'b010) || (f3 == 3'b011)))
      dec_d.illegal = 1'b1;
    if (is_jalr && (f3 != 3'b000))
      dec_d.illegal = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Elastic buffer control
  // ---------------------------------------------------------------------------
  state_t               state_reg, state_next;
  dec_t                 out_reg, out_next;
  dec_t                 skid_reg, skid_next;
  logic [CNT_WIDTH-1:0] count_reg, count_next;
  logic                 accept, consume;

  // Ready is derived from registered state only.
  assign in_ready_o  = (state_reg != ST_TWO);
  assign out_valid_o = (state_reg != ST_EMPTY);
  assign accept      = in_valid_i & in_ready_o;
  assign consume     = out_valid_o & out_ready_i;

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    skid_next  = skid_reg;
    // A consume coinciding with a flush was still handed to execute.
    count_next = consume ? count_reg + CNT_WIDTH'(1) : count_reg;

    if (flush_i) begin
      // Flush wins over everything: buffers empty, incoming insn dropped.
      state_next = ST_EMPTY;
    end else begin
      unique case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            out_next   = dec_d;
            state_next = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            out_next = dec_d;
          end else if (accept) begin
            skid_next  = dec_d;
            state_next = ST_TWO;
          end else if (consume) begin
            state_next = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready_o is low here, so no accept can happen.
          if (consume) begin
            out_next   = skid_reg;
            state_next = ST_ONE;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_EMPTY;
      out_reg   <= '0;
      skid_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      skid_reg  <= skid_next;
      count_reg <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign pc_o      = out_reg.pc;
  assign insn_o    = out_reg.insn;
  assign opcode_o  = out_reg.opcode;
  assign rd_o      = out_reg.rd;
  assign rs1_o     = out_reg.rs1;
  assign rs2_o     = out_reg.rs2;
  assign funct3_o  = out_reg.funct3;
  assign funct7_o  = out_reg.funct7;
  assign shamt_o   = out_reg.shamt;
  assign imm_o     = out_reg.imm;
  assign illegal_o = out_reg.illegal;
  assign count_o   = count_reg;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//
// Self-checking bench for decode_stage: a table of directed instructions with
// hand-computed decoded fields, followed by hand-written sequences for
// back-pressure, flush and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] insn_i = '0;
  logic [31:0] pc_i = '0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] insn_o;
  logic [6:0]  opcode_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [4:0]  shamt_o;
  logic [31:0] imm_o;
  logic        illegal_o;
  logic [15:0] count_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decode_stage #(
    .DWIDTH(32),
    .AWIDTH(32),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .insn_i(insn_i),
    .pc_i(pc_i),
    .flush_i(flush_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .pc_o(pc_o),
    .insn_o(insn_o),
    .opcode_o(opcode_o),
    .rd_o(rd_o),
    .rs1_o(rs1_o),
    .rs2_o(rs2_o),
    .funct3_o(funct3_o),
    .funct7_o(funct7_o),
    .shamt_o(shamt_o),
    .imm_o(imm_o),
    .illegal_o(illegal_o),
    .count_o(count_o)
  );

  typedef struct {
    logic [31:0] insn;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] insn, input logic [6:0] op,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] sh,
                              input logic [31:0] imm, input logic ill);
    vec_t v;
    v.insn = insn; v.opcode = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.shamt = sh; v.imm = imm; v.ill = ill;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_cnt;
  logic [31:0] bp[5];
  int          sent, recv;
  logic        acc, con;

  initial begin
    exp_cnt = '0;

    // ---------------- reset state ----------------
    #2;
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_imm", imm_o, 32'd0);
    check("rst_illegal", 32'(illegal_o), 32'd0);
    check("rst_insn", insn_o, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready_o), 32'd1);
    check("rst_out_valid_rel", 32'(out_valid_o), 32'd0);

    // ---------------- vector table ----------------
    //             insn          op     rd  rs1 rs2 f3    f7     sh  imm            ill
    vecs.push_back(mk(32'h007302B3, 7'h33, 5, 6, 7, 3'd0, 7'h00, 0, 32'h00000000, 1'b0)); // ADD
    vecs.push_back(mk(32'h40335293, 7'h13, 5, 6, 0, 3'd5, 7'h20, 3, 32'h00000003, 1'b0)); // SRAI
    vecs.push_back(mk(32'h007312B3, 7'h33, 5, 6, 7, 3'd1, 7'h00, 7, 32'h00000000, 1'b0)); // SLL
    vecs.push_back(mk(32'hFE208EE3, 7'h63, 0, 1, 2, 3'd0, 7'h00, 0, 32'hFFFFFFFC, 1'b0)); // BEQ -4
    vecs.push_back(mk(32'h001000EF, 7'h6F, 1, 0, 0, 3'd0, 7'h00, 0, 32'h00000800, 1'b0)); // JAL 2048
    vecs.push_back(mk(32'hFE512C23, 7'h23, 0, 2, 5, 3'd2, 7'h00, 0, 32'hFFFFFFF8, 1'b0)); // SW -8
    vecs.push_back(mk(32'hABCDE1B7, 7'h37, 3, 0, 0, 3'd0, 7'h00, 0, 32'hABCDE000, 1'b0)); // LUI
    vecs.push_back(mk(32'h12345117, 7'h17, 2, 0, 0, 3'd0, 7'h00, 0, 32'h12345000, 1'b0)); // AUIPC
    vecs.push_back(mk(32'hFFF10093, 7'h13, 1, 2, 0, 3'd0, 7'h00, 0, 32'hFFFFFFFF, 1'b0)); // ADDI -1
    vecs.push_back(mk(32'h00000000, 7'h00, 0, 0, 0, 3'd0, 7'h00, 0, 32'h00000000, 1'b1)); // all zero
    vecs.push_back(mk(32'hFFFFFFFF, 7'h7F, 0, 0, 0, 3'd0, 7'h00, 0, 32'h00000000, 1'b1)); // all ones
    vecs.push_back(mk(32'h027302B3, 7'h33, 5, 6, 7, 3'd0, 7'h01, 0, 32'h00000000, 1'b1)); // ADD f7=1
    vecs.push_back(mk(32'h00013083, 7'h03, 1, 2, 0, 3'd3, 7'h00, 0, 32'h00000000, 1'b1)); // load f3=011
    vecs.push_back(mk(32'h407312B3, 7'h33, 5, 6, 7, 3'd1, 7'h20, 7, 32'h00000000, 1'b1)); // SLL f7=20

    out_ready_i = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      in_valid_i = 1'b1;
      insn_i     = vecs[i].insn;
      pc_i       = 32'h1000 + 32'(i) * 4;
      tick();
      in_valid_i = 1'b0;
      check("vec_out_valid", 32'(out_valid_o), 32'd1);
      check("vec_pc", pc_o, 32'h1000 + 32'(i) * 4);
      check("vec_insn", insn_o, vecs[i].insn);
      check("vec_opcode", 32'(opcode_o), 32'(vecs[i].opcode));
      check("vec_rd", 32'(rd_o), 32'(vecs[i].rd));
      check("vec_rs1", 32'(rs1_o), 32'(vecs[i].rs1));
      check("vec_rs2", 32'(rs2_o), 32'(vecs[i].rs2));
      check("vec_funct3", 32'(funct3_o), 32'(vecs[i].f3));
      check("vec_funct7", 32'(funct7_o), 32'(vecs[i].f7));
      check("vec_shamt", 32'(shamt_o), 32'(vecs[i].shamt));
      check("vec_imm", imm_o, vecs[i].imm);
      check("vec_illegal", 32'(illegal_o), 32'(vecs[i].ill));
      tick();
      exp_cnt = exp_cnt + 16'd1;
      check("vec_count", 32'(count_o), 32'(exp_cnt));
      check("vec_drained", 32'(out_valid_o), 32'd0);
      $display("[TB] vec %0d insn=%08h imm=%08h illegal=%0b count=%0d",
               i, insn_o, imm_o, illegal_o, count_o);
    end

    // ---------------- back-pressure stream ----------------
    bp[0] = 32'h007302B3;
    bp[1] = 32'h007312B3;
    bp[2] = 32'h40335293;
    bp[3] = 32'hABCDE1B7;
    bp[4] = 32'h001000EF;
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 40 && recv < 5; cyc++) begin
      out_ready_i = (cyc >= 4);
      in_valid_i  = (sent < 5);
      insn_i      = bp[(sent < 5) ? sent : 0];
      pc_i        = 32'h2000 + 32'(sent) * 4;
      #3;
      if (cyc == 2 || cyc == 3) begin
        check("bp_in_ready_low", 32'(in_ready_o), 32'd0);
        check("bp_accepted_two", 32'(sent), 32'd2);
        check("bp_hold_insn", insn_o, bp[0]);
      end
      acc = in_valid_i && in_ready_o;
      con = out_valid_o && out_ready_i;
      if (con) begin
        check("bp_order", insn_o, bp[recv]);
        $display("[TB] bp out %0d insn=%08h pc=%08h", recv, insn_o, pc_o);
        recv++;
      end
      if (acc) sent++;
      tick();
    end
    in_valid_i = 1'b0;
    check("bp_received", 32'(recv), 32'd5);
    exp_cnt = exp_cnt + 16'd5;
    check("bp_count", 32'(count_o), 32'(exp_cnt));

    // ---------------- flush with both entries full ----------------
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    insn_i      = 32'hFFF10093;
    tick();
    insn_i      = 32'h12345117;
    tick();
    check("fl_full", 32'(in_ready_o), 32'd0);
    insn_i      = 32'hABCDE1B7;
    flush_i     = 1'b1;
    tick();
    flush_i     = 1'b0;
    in_valid_i  = 1'b0;
    check("fl_out_valid", 32'(out_valid_o), 32'd0);
    check("fl_in_ready", 32'(in_ready_o), 32'd1);
    check("fl_count", 32'(count_o), 32'(exp_cnt));
    out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fl_nothing_out", 32'(out_valid_o), 32'd0);
    end
    check("fl_count_after", 32'(count_o), 32'(exp_cnt));
    $display("[TB] flush done count=%0d", count_o);

    // ---------------- consume in the same cycle as flush ----------------
    in_valid_i = 1'b1;
    insn_i     = 32'h007302B3;
    tick();
    in_valid_i = 1'b0;
    flush_i    = 1'b1;
    tick();
    flush_i    = 1'b0;
    exp_cnt    = exp_cnt + 16'd1;
    check("flc_count", 32'(count_o), 32'(exp_cnt));
    check("flc_out_valid", 32'(out_valid_o), 32'd0);
    $display("[TB] flush+consume count=%0d", count_o);

    // ---------------- asynchronous reset mid-stream ----------------
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    insn_i      = 32'hABCDE1B7;
    tick();
    in_valid_i  = 1'b0;
    check("ar_pre_valid", 32'(out_valid_o), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid_o), 32'd0);
    check("ar_count", 32'(count_o), 32'd0);
    check("ar_imm", imm_o, 32'd0);
    check("ar_insn", insn_o, 32'd0);
    check("ar_rd", 32'(rd_o), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    check("ar_in_ready", 32'(in_ready_o), 32'd1);
    $display("[TB] async reset done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, flow-controlled RV32I decode stage. It accepts fetched instructions on a valid/ready interface and emits decoded fields one cycle later on a valid/ready interface. A 2-entry skid buffer sustains one instruction per cycle under back-pressure. It adds flush, illegal-instruction detection, immediate generation for all formats, and a retired-decode counter.

Parameters:
DWIDTH, 32, instruction/immediate width (must be 32 for RV32I field positions).
AWIDTH, 32, PC width.
CNT_WIDTH, 16, width of the decoded-instruction counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
in_valid_i  in  1  fetch presents an instruction.
in_ready_o  out  1  stage can accept an instruction.
insn_i  in  DWIDTH  raw instruction.
pc_i  in  AWIDTH  instruction PC.
flush_i  in  1  discard all buffered and incoming instructions.
out_valid_o  out  1  decoded outputs are valid.
out_ready_i  in  1  execute consumes the outputs.
pc_o  out  AWIDTH  PC of the decoded instruction.
insn_o  out  DWIDTH  raw instruction passthrough.
opcode_o  out  7  insn[6:0].
rd_o  out  5  insn[11:7] for R/I/U/J formats, else 0.
rs1_o  out  5  insn[19:15] for R/I/S/B formats, else 0.
rs2_o  out  5  insn[24:20] for R/S/B formats, else 0.
funct3_o  out  3  insn[14:12] for R/I/S/B formats, else 0.
funct7_o  out  7  insn[31:25] for R format and for OP-IMM shifts, else 0.
shamt_o  out  5  insn[24:20] for shifts (OP funct3 001/101, OP-IMM funct3 001/101), else 0.
imm_o  out  DWIDTH  sign-extended immediate, 0 for R format.
illegal_o  out  1  instruction is not valid RV32I.
count_o  out  CNT_WIDTH  number of instructions handed to execute.

Behaviour:
- Reset (rst=0, asynchronous): out_valid_o=0, in_ready_o=1 after release, all data outputs=0, illegal_o=0, count_o=0, skid entry empty.
- Storage: an output register (OUT) and a skid register (SKID). Entry states: EMPTY (OUT empty), ONE (OUT full, SKID empty), TWO (both full).
- in_ready_o = ~SKID valid, registered with no combinational path from out_ready_i.
- Accept = in_valid_i & in_ready_o. Consume = out_valid_o & out_ready_i.
- Latency: an instruction accepted in cycle N appears on the outputs in cycle N+1 when OUT is empty or consumed in cycle N.
- Decode logic sits before the storage registers. SKID holds decoded fields, not raw insn.
- EMPTY: on accept, go to ONE.
- ONE: accept & consume stays ONE (OUT reloads). Accept & ~consume goes to TWO. ~accept & consume goes to EMPTY.
- TWO: on consume, SKID moves into OUT and the state goes to ONE. Accept is impossible in TWO because in_ready_o=0.
- Outputs hold stable while out_valid_o=1 and out_ready_i=0.
- Ordering is strictly FIFO. No drop or duplication.
- Immediate formats:
  - I: insn[31:20] sign-extended. For OP-IMM shifts, imm = zero-extended shamt.
  - S: {insn[31:25],insn[11:7]} sign-extended.
  - B: {insn[31],insn[7],insn[30:25],insn[11:8],0} sign-extended.
  - U: {insn[31:12],12'b0}.
  - J: {insn[31],insn[19:12],insn[20],insn[30:21],0} sign-extended.
- Opcode classes:
  - R: 0110011.
  - I: 0010011, 0000011, 1100111, 1110011, 0001111.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
- illegal_o=1 when any of the following holds:
  - the opcode is outside the listed set;
  - insn[1:0] != 11;
  - R funct7 is not 0000000/0100000, or funct7 is 0100000 with funct3 not 000/101;
  - OP-IMM shift has funct7 not 0000000/0100000 (0100000 allowed only for funct3 101);
  - the load funct3 is 011/110/111;
  - the store funct3 is above 010;
  - the branch funct3 is 010/011;
  - JALR funct3 is not 000.
- Fields of an illegal instruction are still decoded and forwarded.
- flush_i=1 (synchronous, dominant): at the next edge OUT and SKID are emptied and out_valid_o=0. An instruction presented in the same cycle is dropped. in_ready_o=1 the following cycle. count_o is unaffected by dropped instructions.
- count_o increments on each consume and wraps modulo 2^CNT_WIDTH.
  - A consume in the same cycle as flush_i still counts.
- Reset mid-operation: state returns immediately to EMPTY with all outputs cleared.

Test Plan:
- ADD x5,x6,x7 (0x007302B3), out_ready_i=1 -> next cycle out_valid_o=1, opcode=0110011, rd=5, rs1=6, rs2=7, funct7=0, imm=0, illegal=0, count=1.
- SRAI x5,x6,3 (0x40335293) -> rs2_o=0, shamt_o=3, funct7_o=0100000, imm_o=3. SLL x5,x6,x7 (0x007312B3) -> rs2_o=7, shamt_o=7.
- Immediates:
  - BEQ x1,x2,-4 (0xFE208EE3) -> imm=0xFFFFFFFC, rd=0.
  - JAL x1,2048 (0x001000EF) -> imm=0x00000800.
  - SW x5,-8(x2) (0xFE512C23) -> imm=0xFFFFFFF8.
  - LUI x3,0xABCDE (0xABCDE1B7) -> imm=0xABCDE000.
- Back-pressure: stream 5 back-to-back instructions with out_ready_i=0 -> two accepted, in_ready_o=0 from the second accept's next cycle. Releasing out_ready_i -> all 5 emerge in order, count=5.
- Flush with TWO full plus a new in_valid_i -> out_valid_o=0 next cycle, nothing emerges, count unchanged. Assert rst=0 mid-stream -> outputs 0 immediately.
- Illegal: 0x00000000, 0xFFFFFFFF, and ADD with funct7=0000001 -> illegal_o=1 with fields still decoded.
